// File: rtl/lsu_seq_if.sv
// Access-type codes shared by decode, the sequencer and its bench, plus the
// data-memory bus interface driven by the load/store sequencer.

package lsu_seq_pkg;
    localparam int MEM_ACCESS_TYPE_WIDTH = 3;
    // bit 2 marks a store, bits 1:0 give the size (1 byte, 2 half, 3 word)
    localparam logic [MEM_ACCESS_TYPE_WIDTH-1:0] MEM_ACCESS_TYPE_NONE = 3'd0;
    localparam logic [MEM_ACCESS_TYPE_WIDTH-1:0] MEM_ACCESS_TYPE_LB   = 3'd1;
    localparam logic [MEM_ACCESS_TYPE_WIDTH-1:0] MEM_ACCESS_TYPE_LH   = 3'd2;
    localparam logic [MEM_ACCESS_TYPE_WIDTH-1:0] MEM_ACCESS_TYPE_LW   = 3'd3;
    localparam logic [MEM_ACCESS_TYPE_WIDTH-1:0] MEM_ACCESS_TYPE_SB   = 3'd5;
    localparam logic [MEM_ACCESS_TYPE_WIDTH-1:0] MEM_ACCESS_TYPE_SH   = 3'd6;
    localparam logic [MEM_ACCESS_TYPE_WIDTH-1:0] MEM_ACCESS_TYPE_SW   = 3'd7;
endpackage

interface lsu_seq_if #(
    parameter int ADDR_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        be;
    logic [31:0]       wdata;
    logic              gnt;
    logic              rvalid;
    logic [31:0]       rdata;

    modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/lsu_seq.sv
// Load/store sequencer: takes one decoded memory op, runs a req/gnt/rvalid
// bus transaction with byte steering, aligns/extends load data, and flags
// misaligned accesses and bus timeouts. Stalls the pipeline via busy.

module lsu_seq
    import lsu_seq_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [MEM_ACCESS_TYPE_WIDTH-1:0] access_type,
    input  logic                             sign_ext,
    input  logic [ADDR_W-1:0]                addr,
    input  logic [31:0]                      wdata,
    output logic                             busy,
    output logic                             done,
    output logic [31:0]                      rdata,
    output logic                             misalign,
    output logic                             bus_err,
    lsu_seq_if.master                        mem
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, FIN} state_t;

    state_t                           state_q, state_d;
    logic [7:0]                       cnt_q;
    logic [MEM_ACCESS_TYPE_WIDTH-1:0] type_q;
    logic                             sext_q;
    logic [ADDR_W-1:0]                addr_q;
    logic [31:0]                      wdata_q;
    logic                             mis_q;
    logic                             err_q;
    logic [31:0]                      rdata_q;

    // FSM strobes from the next-state logic into the datapath
    logic latch, cap, tmo, cnt_clr, cnt_inc;

    logic op_valid, mis_in;
    logic is_byte_q, is_half_q, is_store_q;
    logic [31:0] shifted;
    logic [31:0] load_val;

    assign op_valid = (access_type != MEM_ACCESS_TYPE_NONE);

    // Alignment is judged on the incoming op so a bad access never reaches the bus
    always_comb begin
        mis_in = 1'b0;
        if (access_type == MEM_ACCESS_TYPE_LH || access_type == MEM_ACCESS_TYPE_SH)
            mis_in = addr[0];
        else if (access_type == MEM_ACCESS_TYPE_LW || access_type == MEM_ACCESS_TYPE_SW)
            mis_in = (addr[1:0] != 2'b00);
    end

    assign is_byte_q  = (type_q == MEM_ACCESS_TYPE_LB) || (type_q == MEM_ACCESS_TYPE_SB);
    assign is_half_q  = (type_q == MEM_ACCESS_TYPE_LH) || (type_q == MEM_ACCESS_TYPE_SH);
    assign is_store_q = (type_q == MEM_ACCESS_TYPE_SB) || (type_q == MEM_ACCESS_TYPE_SH) ||
                        (type_q == MEM_ACCESS_TYPE_SW);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state and datapath strobes; timeout only when no progress this cycle
    always_comb begin
        state_d = state_q;
        latch   = 1'b0;
        cap     = 1'b0;
        tmo     = 1'b0;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && op_valid) begin
                    latch   = 1'b1;
                    cnt_clr = 1'b1;
                    state_d = mis_in ? FIN : REQ;
                end
            end
            REQ: begin
                if (mem.gnt) begin
                    cnt_clr = 1'b1;
                    state_d = is_store_q ? FIN : RESP;
                end else if (cnt_q == 8'(TIMEOUT)) begin
                    tmo     = 1'b1;
                    state_d = FIN;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            RESP: begin
                if (mem.rvalid) begin
                    cap     = 1'b1;
                    state_d = FIN;
                end else if (cnt_q == 8'(TIMEOUT)) begin
                    tmo     = 1'b1;
                    state_d = FIN;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Lane extraction and extension of the returned word
    always_comb begin
        shifted  = mem.rdata >> {addr_q[1:0], 3'b000};
        load_val = mem.rdata;
        if (is_byte_q)
            load_val = {{24{sext_q & shifted[7]}}, shifted[7:0]};
        else if (is_half_q)
            load_val = addr_q[1] ? {{16{sext_q & mem.rdata[31]}}, mem.rdata[31:16]}
                                 : {{16{sext_q & mem.rdata[15]}}, mem.rdata[15:0]};
    end

    // Operation latches, wait counter, status flags and load result
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            type_q  <= MEM_ACCESS_TYPE_NONE;
            sext_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            mis_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (latch) begin
                type_q  <= access_type;
                sext_q  <= sign_ext;
                addr_q  <= addr;
                wdata_q <= wdata;
                mis_q   <= mis_in;
                err_q   <= 1'b0;
            end
            if (cnt_clr)      cnt_q <= '0;
            else if (cnt_inc) cnt_q <= cnt_q + 8'd1;
            if (cap) rdata_q <= load_val;
            if (tmo) begin
                err_q   <= 1'b1;
                rdata_q <= '0;
            end
        end
    end

    // Bus drive: fields come from the latched op so they hold steady until gnt
    always_comb begin
        mem.req   = (state_q == REQ);
        mem.we    = is_store_q;
        mem.addr  = {addr_q[ADDR_W-1:2], 2'b00};
        mem.be    = 4'b0000;
        mem.wdata = wdata_q;
        if (is_byte_q) begin
            mem.be    = 4'b0001 << addr_q[1:0];
            mem.wdata = {4{wdata_q[7:0]}};
        end else if (is_half_q) begin
            mem.be    = addr_q[1] ? 4'b1100 : 4'b0011;
            mem.wdata = {2{wdata_q[15:0]}};
        end else if (type_q != MEM_ACCESS_TYPE_NONE) begin
            mem.be    = 4'b1111;
        end
    end

    // Stall covers the accepting cycle; status only visible with done
    always_comb begin
        busy     = (start && op_valid && state_q == IDLE) || state_q == REQ || state_q == RESP;
        done     = (state_q == FIN);
        misalign = done & mis_q;
        bus_err  = done & err_q;
        rdata    = rdata_q;
    end

endmodule

// File: tb/tb_lsu_seq.sv
// Scoreboard bench for lsu_seq: expected results are queued at start and
// popped when done fires; bus fields, busy/req/done timing checked per cycle.

module tb_lsu_seq;
    import lsu_seq_pkg::*;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [MEM_ACCESS_TYPE_WIDTH-1:0] access_type;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy, done, misalign, bus_err;
    logic [31:0] rdata;

    lsu_seq_if #(.ADDR_W(32)) mem ();

    lsu_seq #(.ADDR_W(32), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .access_type(access_type),
        .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .busy(busy),
        .done(done), .rdata(rdata), .misalign(misalign), .bus_err(bus_err),
        .mem(mem)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd;
        logic        mis;
        logic        err;
    } exp_t;

    exp_t        sbq[$];
    int          vec_cnt = 0;
    int          err_cnt = 0;
    logic [31:0] last_rd = 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_done"},  done, 0);
        chk({tag, "_rdata"}, rdata, 0);
        chk({tag, "_mis"},   misalign, 0);
        chk({tag, "_err"},   bus_err, 0);
        chk({tag, "_req"},   mem.req, 0);
        chk({tag, "_we"},    mem.we, 0);
        chk({tag, "_addr"},  mem.addr, 0);
        chk({tag, "_be"},    mem.be, 0);
        chk({tag, "_wdata"}, mem.wdata, 0);
    endtask

    // gdly/rdly: cycles of gnt/rvalid delay, negative = never arrives
    task automatic do_op(input string tag, input logic [2:0] t, input logic s,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int gdly, input int rdly, input logic [31:0] rword);
        logic        ld, st, mis, err;
        int          sz, lat, req_end;
        logic [3:0]  ebe;
        logic [31:0] ewd, erd, tmp;
        exp_t        e;
        bit          got;

        ld = (t == MEM_ACCESS_TYPE_LB) || (t == MEM_ACCESS_TYPE_LH) || (t == MEM_ACCESS_TYPE_LW);
        st = !ld;
        sz = (t == MEM_ACCESS_TYPE_LB || t == MEM_ACCESS_TYPE_SB) ? 1 :
             (t == MEM_ACCESS_TYPE_LH || t == MEM_ACCESS_TYPE_SH) ? 2 : 4;
        mis = (sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'b00);
        err = !mis && (gdly < 0 || (ld && rdly < 0));
        case (sz)
            1:       begin ebe = 4'b0001 << a[1:0]; ewd = {4{wd[7:0]}}; end
            2:       begin ebe = a[1] ? 4'b1100 : 4'b0011; ewd = {2{wd[15:0]}}; end
            default: begin ebe = 4'b1111; ewd = wd; end
        endcase
        erd = last_rd;
        if (err) erd = 32'h0;
        else if (!mis && ld) begin
            tmp = rword >> (8 * a[1:0]);
            if (sz == 1)      erd = {{24{s & tmp[7]}}, tmp[7:0]};
            else if (sz == 2) begin
                tmp = rword >> (16 * a[1]);
                erd = {{16{s & tmp[15]}}, tmp[15:0]};
            end
            else              erd = rword;
        end
        if (mis)                 lat = 1;
        else if (gdly < 0)       lat = TMO + 2;
        else if (st)             lat = 2 + gdly;
        else if (rdly < 0)       lat = gdly + TMO + 3;
        else                     lat = 3 + gdly + rdly;
        req_end = (gdly < 0) ? TMO + 1 : 1 + gdly;
        e = '{erd, mis, err};
        sbq.push_back(e);

        @(negedge clk);
        start = 1'b1; access_type = t; sign_ext = s; addr = a; wdata = wd;
        mem.gnt = 1'b0; mem.rvalid = 1'b0;
        #1;
        chk({tag, "_busy0"}, busy, 1);
        chk({tag, "_done0"}, done, 0);

        got = 0;
        for (int c = 1; c <= lat + 4 && !got; c++) begin
            @(negedge clk);
            start       = 1'b0;
            access_type = MEM_ACCESS_TYPE_NONE;
            mem.gnt     = !mis && gdly >= 0 && c == 1 + gdly;
            mem.rvalid  = ld && !mis && gdly >= 0 && rdly >= 0 && c == 2 + gdly + rdly;
            mem.rdata   = mem.rvalid ? rword : $urandom();
            #1;
            if (c <= lat) begin
                chk({tag, "_busy"}, busy, c < lat);
                chk({tag, "_done"}, done, c == lat);
                chk({tag, "_req"},  mem.req, !mis && c <= req_end);
            end
            if (c == 1 && !mis) begin
                chk({tag, "_maddr"}, mem.addr, {a[31:2], 2'b00});
                chk({tag, "_be"},    mem.be, ebe);
                chk({tag, "_we"},    mem.we, st);
                chk({tag, "_mwdata"}, mem.wdata, ewd);
            end
            if (done) begin
                got = 1;
                if (sbq.size() == 0) chk({tag, "_sb_empty"}, 0, 1);
                else begin
                    e = sbq.pop_front();
                    chk({tag, "_rdata"}, rdata, e.rd);
                    chk({tag, "_mis"},   misalign, e.mis);
                    chk({tag, "_err"},   bus_err, e.err);
                end
            end
        end
        if (!got) begin
            chk({tag, "_no_done"}, 0, 1);
            if (sbq.size() != 0) e = sbq.pop_front();
        end
        last_rd = erd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; access_type = MEM_ACCESS_TYPE_NONE;
        sign_ext = 1'b0; addr = '0; wdata = '0;
        mem.gnt = 1'b0; mem.rvalid = 1'b0; mem.rdata = '0;
        repeat (2) @(negedge clk);
        #1 chk_all_zero("reset");
        rst = 1'b0;

        do_op("sw",   MEM_ACCESS_TYPE_SW, 0, 32'h1004, 32'hDEADBEEF, 0, 0, 0);
        do_op("lb",   MEM_ACCESS_TYPE_LB, 1, 32'h2003, 0, 0, 0, 32'h80FF1234);
        do_op("lbu",  MEM_ACCESS_TYPE_LB, 0, 32'h2003, 0, 0, 0, 32'h80FF1234);
        do_op("lh",   MEM_ACCESS_TYPE_LH, 1, 32'h2002, 0, 0, 0, 32'hABCD0000);
        do_op("sh",   MEM_ACCESS_TYPE_SH, 0, 32'h0010, 32'h5A5A1234, 0, 0, 0);
        do_op("lwmis", MEM_ACCESS_TYPE_LW, 0, 32'h3001, 0, 0, 0, 0);
        do_op("lhmis", MEM_ACCESS_TYPE_LH, 1, 32'h3003, 0, 0, 0, 0);
        do_op("swtmo", MEM_ACCESS_TYPE_SW, 0, 32'h1000, 32'h11112222, -1, 0, 0);
        do_op("sw2",  MEM_ACCESS_TYPE_SW, 0, 32'h1008, 32'h33334444, 2, 0, 0);
        do_op("lw",   MEM_ACCESS_TYPE_LW, 0, 32'h2000, 0, 1, 2, 32'hCAFEF00D);
        do_op("lhu",  MEM_ACCESS_TYPE_LH, 0, 32'h2002, 0, 0, 1, 32'h80017FFF);
        do_op("lbp",  MEM_ACCESS_TYPE_LB, 1, 32'h2001, 0, 0, 0, 32'h00007F00);
        do_op("sb",   MEM_ACCESS_TYPE_SB, 0, 32'h0002, 32'h000000AB, 1, 0, 0);
        do_op("lwtmo", MEM_ACCESS_TYPE_LW, 0, 32'h2004, 0, 0, -1, 0);
        do_op("lw2",  MEM_ACCESS_TYPE_LW, 0, 32'h2008, 0, 0, 0, 32'h01234567);

        // reset while waiting for rvalid abandons the load
        @(negedge clk);
        start = 1'b1; access_type = MEM_ACCESS_TYPE_LW; addr = 32'h4000;
        @(negedge clk);
        start = 1'b0; access_type = MEM_ACCESS_TYPE_NONE; mem.gnt = 1'b1;
        @(negedge clk);
        mem.gnt = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; mem.rvalid = 1'b1; mem.rdata = 32'h12345678;
        #1 chk_all_zero("rst_mid");
        last_rd = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem.rvalid = 1'b0;
            #1;
            chk("late_rvalid_done", done, 0);
            chk("late_rvalid_rdata", rdata, 0);
        end

        // NONE is a no-op
        @(negedge clk);
        start = 1'b1; access_type = MEM_ACCESS_TYPE_NONE;
        #1 chk("none_busy", busy, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            chk("none_busy_after", busy, 0);
            chk("none_done", done, 0);
        end

        do_op("lb_post", MEM_ACCESS_TYPE_LB, 1, 32'h5000, 0, 0, 0, 32'h000000F0);
        chk("sb_drained", sbq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/lsu_seq.md
# lsu_seq

Multi-cycle load/store sequencer between the decode/execute stage and the data-memory bus. It accepts one decoded memory operation (access type, sign-extension flag, ALU-computed address, rs2 store data) and drives a req/gnt/rvalid bus transaction, with byte-lane steering and byte enables. Load data is aligned and extended before it returns. The block stalls the pipeline through `busy` until a one-cycle `done`. It also flags misaligned accesses and bus timeouts.

## Interface
- `ADDR_W`, 32, address width
- `TIMEOUT`, 255, max wait cycles for `mem_gnt` or `mem_rvalid` before bus error (1..255)
- `clk`  in  1  clock; everything is updated on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  memory instruction present this cycle; sampled only in IDLE
- `access_type`  in  `MEM_ACCESS_TYPE_WIDTH`  `MEM_ACCESS_TYPE_*` code from decode
- `sign_ext`  in  1  loads: 1 = sign-extend, 0 = zero-extend
- `addr`  in  ADDR_W  byte address (ALU result)
- `wdata`  in  32  store data (rs2)
- `busy`  out  1  pipeline stall request
- `done`  out  1  one-cycle completion pulse
- `rdata`  out  32  aligned/extended load result, valid with `done`, held until the next load completion
- `misalign`  out  1  qualifies `done`: access was misaligned, no bus cycle was issued
- `bus_err`  out  1  qualifies `done`: timeout
- `mem_req`  out  1  bus request
- `mem_we`  out  1  1 = write
- `mem_addr`  out  ADDR_W  word-aligned address, `{addr[ADDR_W-1:2],2'b00}`
- `mem_be`  out  4  byte enables
- `mem_wdata`  out  32  lane-replicated store data
- `mem_gnt`  in  1  request accepted this cycle (transfer occurs when `mem_req & mem_gnt`)
- `mem_rvalid`  in  1  read data valid
- `mem_rdata`  in  32  read data word

## Operation
- **States:** IDLE, REQ, RESP, FIN.
- **Start in IDLE:**
  - `start=1` with `access_type == MEM_ACCESS_TYPE_NONE` is a no-op: no `busy`, no `done`.
  - Otherwise `access_type`, `sign_ext`, `addr` and `wdata` are latched.
- **Alignment check at start:**
  - Half access with `addr[0]=1` is misaligned.
  - Word access with `addr[1:0]!=0` is misaligned.
  - Misaligned: go to FIN with `misalign` set and no bus cycle.
  - Aligned: go to REQ.
- **REQ:**
  - `mem_req=1`; `mem_addr`, `mem_we`, `mem_be` and `mem_wdata` are stable until `mem_gnt`.
  - On `mem_gnt`: a write goes to FIN; a read goes to RESP.
- **RESP:** `mem_req=0`. `mem_rvalid` is sampled only here. On `mem_rvalid`, the extracted load value is captured and the state goes to FIN.
- **FIN:** `done=1`, `busy=0`, with `misalign`/`bus_err` qualifying. The next state is IDLE. `start` is ignored in FIN.
- **Byte enables and store data** (`a = addr[1:0]`):
  - Byte: `be = 4'b0001 << a`, `mem_wdata = {4{wdata[7:0]}}`.
  - Half: `be = a[1] ? 4'b1100 : 4'b0011`, `mem_wdata = {2{wdata[15:0]}}`.
  - Word: `be = 4'b1111`, `mem_wdata = wdata`.
  - Reads drive the same enables.
- **Load extraction:**
  - Byte = `mem_rdata[8a+7:8a]`.
  - Half = `mem_rdata[16a[1]+15:16a[1]]`.
  - Result is extended to 32 bits per `sign_ext`.
  - Word loads pass through unchanged.
- **Timeout:**
  - An 8-bit wait counter clears on entry to REQ and on `mem_gnt`, and increments each cycle in REQ/RESP without progress.
  - When the count reaches TIMEOUT: drop `mem_req`, go to FIN with `bus_err=1`, `rdata=0`.
- **`start` while not IDLE** is ignored. This is a protocol violation upstream.

## Timing
- **Reset:** state IDLE, counter 0, and all outputs 0 (`busy`, `done`, `rdata`, `misalign`, `bus_err`, `mem_req`, `mem_we`, `mem_addr`, `mem_be`, `mem_wdata`).
  - `rst` mid-transaction abandons it; no `done` is produced.
  - `mem_req` is 0 from the first cycle after the reset edge.
- **`busy`:** combinational `(start & type != NONE & state==IDLE) | state==REQ | state==RESP`, so the stall covers the start cycle itself. `busy` is low in the `done` cycle.
- **Store latency:** start in cycle 0 → `mem_req` in cycle 1 → `mem_gnt` in cycle 1 → `done` in cycle 2. Each cycle of `gnt` delay adds one cycle.
- **Load latency:** start in cycle 0 → `gnt` in cycle 1 → `rvalid` in cycle 2 → `done` with `rdata` in cycle 3. Minimum 3 cycles.
- **Misaligned:** start in cycle 0 → `done=misalign=1` in cycle 1.
- **Timeout:** `done=bus_err=1` arrives TIMEOUT+2 cycles after start when `gnt` never comes.
- **Back-to-back:** a new `start` is accepted in the cycle after `done`.

## Test plan
- **SW:** `addr=0x1004`, `wdata=0xDEADBEEF`, `gnt` at first request → `mem_addr=0x1004`, `be=1111`, `we=1`; `done` 2 cycles after start; `busy` high in cycles 0–1 only.
- **LB:** `sign_ext=1`, `addr=0x2003`, `mem_rdata=0x80FF1234`, `gnt` immediate, `rvalid` 1 cycle later → `be=1000`, `rdata=0xFFFFFF80`. Repeat as LBU → `rdata=0x00000080`.
- **LH:** `addr=0x2002`, `mem_rdata=0xABCD0000` → `rdata=0xFFFFABCD`. SH at `addr=0x10`, `wdata=0x5A5A1234` → `be=0011`, `mem_wdata=0x12341234`.
- **Misaligned LW:** `addr=0x3001` → no `mem_req` ever; cycle 1 `done=1`, `misalign=1`. Misaligned LH at `0x3003` → same.
- **Timeout:** TIMEOUT=4, `mem_gnt` held 0 → `done=bus_err=1` at cycle 6, `mem_req` low afterward, `rdata=0`. A subsequent normal SW completes.
- **Sync reset:** `rst` pulsed while in RESP → next cycle all outputs 0, no `done`. A late `mem_rvalid` is ignored. `start` with type NONE → `busy` stays 0.
